discharge_pulse_scheduler: RTL and testbench

- Sequences one EDM discharge cycle at a time: inductor precharge, gap application, breakdown detection, timed discharge (Ton), then deionisation off-time (Toff).
- Takes `is_machine` and the synchronised Ton/Toff from parameter generation, plus `inductor_charging_time` from one-cycle control and `sample_voltage` from ADC sampling.
- Drives the buck-charge and gap-switch enables that feed the PWM stage, and counts normal and null pulses for servo feedback.
- Runs on the 100 MHz system clock.

---
 rtl/discharge_pulse_scheduler.sv | 125 ++++++++++++
 tb/tb_discharge_pulse_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/discharge_pulse_scheduler.sv
// EDM discharge-cycle sequencer: precharge, gap wait, timed discharge, deionisation off-time.
// Moore enables and registered strobes; shadows freeze pulse timing at each cycle start.
module discharge_pulse_scheduler #(
  parameter int unsigned TICK_DIV = 100,
  parameter logic [15:0] BRK_TH   = 16'd1000,
  parameter logic [15:0] WAIT_MAX = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_machine,
  input  logic [15:0] Ton_data,
  input  logic [15:0] Toff_data,
  input  logic [15:0] inductor_charging_time,
  input  logic [15:0] sample_voltage,
  output logic        charge_en,
  output logic        gap_en,
  output logic        pulse_start,
  output logic        null_pulse,
  output logic [15:0] state_timer,
  output logic [7:0]  normal_cnt,
  output logic [7:0]  null_cnt,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHARGE   = 3'd1,
    S_GAP_WAIT = 3'd2,
    S_DISCH    = 3'd3,
    S_OFF      = 3'd4
  } state_t;

  localparam logic [7:0]  TICK8    = TICK_DIV[7:0];
  localparam logic [23:0] CYC_MAX  = 24'hFF_FFFF;
  localparam logic [23:0] WAIT_END = {8'd0, WAIT_MAX} - 24'd1;

  state_t      r_state, w_next;
  logic [23:0] r_cyc;
  logic [23:0] r_ton_ticks, r_toff_ticks;
  logic [15:0] r_tc_sh;
  logic        r_abort;
  logic        r_pulse_start, r_null_pulse;
  logic [7:0]  r_normal_cnt, r_null_cnt;

  logic w_start_ok, w_chg_done, w_dis_done, w_off_done, w_brk, w_tmo;
  logic w_abort, w_load, w_brk_evt, w_null_evt;

  assign w_start_ok = is_machine && (Ton_data != 16'd0);
  assign w_chg_done = (r_tc_sh == 16'd0) || (r_cyc == {8'd0, r_tc_sh} - 24'd1);
  assign w_dis_done = (r_cyc == r_ton_ticks - 24'd1);
  assign w_off_done = (r_toff_ticks == 24'd0) || (r_cyc == r_toff_ticks - 24'd1);
  assign w_brk      = (sample_voltage < BRK_TH);
  assign w_tmo      = (r_cyc == WAIT_END);

  // Machining enable dropping mid-pulse sends the gap straight to deionisation.
  assign w_abort = !is_machine &&
                   (r_state == S_CHARGE || r_state == S_GAP_WAIT || r_state == S_DISCH);

  always_comb begin
    // NOTE: default assignment first keeps this combinational block latch-free.
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start_ok) w_next = S_CHARGE;
      S_CHARGE:   if (w_abort) w_next = S_OFF;
                  else if (w_chg_done) w_next = S_GAP_WAIT;
      S_GAP_WAIT: if (w_abort) w_next = S_OFF;
                  else if (w_brk) w_next = S_DISCH;
                  else if (w_tmo) w_next = S_OFF;
      S_DISCH:    if (w_abort || w_dis_done) w_next = S_OFF;
      S_OFF:      if (w_off_done) w_next = (w_start_ok && !r_abort) ? S_CHARGE : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign w_load     = (w_next == S_CHARGE) && (r_state == S_IDLE || r_state == S_OFF);
  assign w_brk_evt  = (r_state == S_GAP_WAIT) && (w_next == S_DISCH);
  assign w_null_evt = (r_state == S_GAP_WAIT) && (w_next == S_OFF) && !w_abort;

  // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cyc         <= '0;
      r_ton_ticks   <= '0;
      r_toff_ticks  <= '0;
      r_tc_sh       <= '0;
      r_abort       <= 1'b0;
      r_pulse_start <= 1'b0;
      r_null_pulse  <= 1'b0;
      r_normal_cnt  <= '0;
      r_null_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)   r_cyc <= '0;
      else if (r_cyc != CYC_MAX) r_cyc <= r_cyc + 24'd1;

      if (w_load) begin
        r_ton_ticks  <= {8'd0, Ton_data}  * {16'd0, TICK8};
        r_toff_ticks <= {8'd0, Toff_data} * {16'd0, TICK8};
        r_tc_sh      <= inductor_charging_time;
      end

      // Abort flag holds through the full off-time, then forces a return to IDLE.
      if (w_abort)                                  r_abort <= 1'b1;
      else if (r_state == S_OFF && w_next != S_OFF) r_abort <= 1'b0;

      r_pulse_start <= w_brk_evt;
      r_null_pulse  <= w_null_evt;
      if (w_brk_evt)  r_normal_cnt <= r_normal_cnt + 8'd1;
      if (w_null_evt) r_null_cnt   <= r_null_cnt + 8'd1;
    end
  end

  always_comb begin
    charge_en   = (r_state == S_CHARGE) || (r_state == S_DISCH);
    gap_en      = (r_state == S_GAP_WAIT) || (r_state == S_DISCH);
    fsm_state   = r_state;
    state_timer = (|r_cyc[23:16]) ? 16'hFFFF : r_cyc[15:0];
    pulse_start = r_pulse_start;
    null_pulse  = r_null_pulse;
    normal_cnt  = r_normal_cnt;
    null_cnt    = r_null_cnt;
  end

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// Directed bench for discharge_pulse_scheduler: expected state segments are queued as
// stimulus is planned and compared against each observed segment as it completes.
module tb_discharge_pulse_scheduler;

  localparam logic [2:0] IDLE = 3'd0, CHARGE = 3'd1, GAP = 3'd2, DISCH = 3'd3, OFF = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_machine;
  logic [15:0] Ton_data, Toff_data, inductor_charging_time, sample_voltage;
  logic        charge_en, gap_en, pulse_start, null_pulse;
  logic [15:0] state_timer;
  logic [7:0]  normal_cnt, null_cnt;
  logic [2:0]  fsm_state;

  discharge_pulse_scheduler #(.TICK_DIV(10), .BRK_TH(16'd1000), .WAIT_MAX(16'd20)) dut (
    .clk(clk), .rst(rst), .is_machine(is_machine), .Ton_data(Ton_data),
    .Toff_data(Toff_data), .inductor_charging_time(inductor_charging_time),
    .sample_voltage(sample_voltage), .charge_en(charge_en), .gap_en(gap_en),
    .pulse_start(pulse_start), .null_pulse(null_pulse), .state_timer(state_timer),
    .normal_cnt(normal_cnt), .null_cnt(null_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    int         len;   // -1: length not checked (IDLE dwell)
    int         ps;
    int         np;
  } seg_t;

  seg_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_normal = 0;
  int   seg_idx = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input int len, input int ps, input int np);
    seg_t e;
    e.st = st; e.len = len; e.ps = ps; e.np = np;
    sb_q.push_back(e);
  endtask

  task automatic wait_enter(input logic [2:0] st, input int budget, input string tag);
    logic [2:0] prev;
    prev = fsm_state;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fsm_state == st && prev != st) return;
      prev = fsm_state;
    end
    checks++;
    assert (fsm_state == st && prev != st) else begin
      failures++;
      $error("FAIL %s: timeout waiting for state %0d, observed state=%0d", tag, st, fsm_state);
    end
  endtask

  // Hold the gap voltage high until GAP_WAIT cycle n, then drop it for breakdown.
  task automatic do_break(input int n, input string tag);
    wait_enter(GAP, 500, {tag, "_gap"});
    repeat (n - 1) @(negedge clk);
    sample_voltage = 16'd500;
    wait_enter(DISCH, 5, {tag, "_disch"});
    sample_voltage = 16'd3000;
  endtask

  // Segment monitor: measures each stretch of constant fsm_state and scores it.
  logic [2:0] mon_st;
  int         mon_len = 0, mon_ps, mon_np, mon_ce, mon_ge;

  task automatic close_seg();
    seg_t e;
    string t;
    t = $sformatf("seg%0d", seg_idx);
    seg_idx++;
    check({t, "_queued"}, longint'(sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check({t, "_state"}, mon_st, e.st);
    if (e.len >= 0) check({t, "_len"}, mon_len, e.len);
    check({t, "_pulse_start"}, mon_ps, e.ps);
    check({t, "_null_pulse"}, mon_np, e.np);
    check({t, "_charge_en"}, mon_ce,
          (e.st == CHARGE || e.st == DISCH) ? ((e.len < 0) ? mon_len : e.len) : 0);
    check({t, "_gap_en"}, mon_ge,
          (e.st == GAP || e.st == DISCH) ? ((e.len < 0) ? mon_len : e.len) : 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_len = 0;
      end else if (mon_len != 0 && fsm_state == mon_st) begin
        mon_len++;
        mon_ps += int'(pulse_start);
        mon_np += int'(null_pulse);
        mon_ce += int'(charge_en);
        mon_ge += int'(gap_en);
      end else begin
        if (mon_len != 0) close_seg();
        mon_st  = fsm_state;
        mon_len = 1;
        mon_ps  = int'(pulse_start);
        mon_np  = int'(null_pulse);
        mon_ce  = int'(charge_en);
        mon_ge  = int'(gap_en);
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; is_machine = 1'b0;
    Ton_data = '0; Toff_data = '0; inductor_charging_time = '0; sample_voltage = 16'd3000;
    repeat (3) @(negedge clk);
    check("rst_state", fsm_state, IDLE);
    check("rst_charge_en", charge_en, 0);
    check("rst_gap_en", gap_en, 0);
    check("rst_timer", state_timer, 0);
    check("rst_normal", normal_cnt, 0);
    check("rst_null", null_cnt, 0);
    push(IDLE, -1, 0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Normal pulse, null pulse, shadowing, abort in one continuous run.
    push(CHARGE, 4, 0, 0); push(GAP, 3, 0, 0); push(DISCH, 30, 1, 0); push(OFF, 50, 0, 0);
    push(CHARGE, 4, 0, 0); push(GAP, 20, 0, 0); push(OFF, 50, 0, 1);
    push(CHARGE, 4, 0, 0); push(GAP, 3, 0, 0); push(DISCH, 30, 1, 0); push(OFF, 50, 0, 0);
    push(CHARGE, 4, 0, 0); push(GAP, 1, 0, 0); push(DISCH, 70, 1, 0); push(OFF, 50, 0, 0);
    push(CHARGE, 4, 0, 0); push(GAP, 2, 0, 0); push(DISCH, 10, 1, 0); push(OFF, 50, 0, 0);
    push(IDLE, -1, 0, 0);
    Ton_data = 16'd3; Toff_data = 16'd5; inductor_charging_time = 16'd4;
    is_machine = 1'b1;
    do_break(3, "p1");
    exp_normal++;
    check("p1_normal_cnt", normal_cnt, exp_normal);
    check("p1_pulse_start", pulse_start, 1);

    wait_enter(GAP, 500, "p2_gap");
    wait_enter(OFF, 50, "p2_off");
    check("p2_null_cnt", null_cnt, 1);
    check("p2_null_pulse", null_pulse, 1);
    check("p2_normal_cnt", normal_cnt, exp_normal);

    do_break(3, "p3");
    Ton_data = 16'd7;
    exp_normal++;
    check("p3_normal_cnt", normal_cnt, exp_normal);

    do_break(1, "p4");
    exp_normal++;
    do_break(2, "p5");
    exp_normal++;
    repeat (9) @(negedge clk);
    is_machine = 1'b0;
    wait_enter(IDLE, 200, "abort_idle");
    repeat (30) @(negedge clk);
    check("abort_stays_idle", fsm_state, IDLE);
    check("abort_normal_cnt", normal_cnt, exp_normal);
    check("abort_null_cnt", null_cnt, 1);

    // Ton=0 must never start a cycle.
    Ton_data = 16'd0;
    is_machine = 1'b1;
    repeat (20) @(negedge clk);
    check("ton0_idle", fsm_state, IDLE);
    check("ton0_charge_en", charge_en, 0);

    // tc=0 and Toff=0 corners, looped until normal_cnt wraps.
    k = 256 - exp_normal;
    for (int i = 0; i < k; i++) begin
      push(CHARGE, 1, 0, 0); push(GAP, 1, 0, 0); push(DISCH, 10, 1, 0); push(OFF, 1, 0, 0);
    end
    push(IDLE, -1, 0, 0);
    inductor_charging_time = 16'd0; Toff_data = 16'd0; sample_voltage = 16'd500;
    Ton_data = 16'd1;
    for (int i = 0; i < k; i++) begin
      wait_enter(DISCH, 50, "wrap_disch");
      exp_normal++;
      if (i == 0 || i == k - 2) check("wrap_normal_cnt", normal_cnt, exp_normal % 256);
      wait_enter(OFF, 50, "wrap_off");
      if (i == k - 1) is_machine = 1'b0;
    end
    wait_enter(IDLE, 10, "wrap_idle");
    check("wrap_to_zero", normal_cnt, exp_normal % 256);

    // Long discharge: state_timer saturates while the 70000-cycle DISCH runs out.
    push(CHARGE, 1, 0, 0); push(GAP, 1, 0, 0); push(DISCH, 70000, 1, 0); push(OFF, 1, 0, 0);
    push(IDLE, -1, 0, 0);
    Ton_data = 16'd7000;
    is_machine = 1'b1;
    wait_enter(DISCH, 50, "sat_disch");
    exp_normal++;
    check("sat_timer_start", state_timer, 0);
    repeat (100) @(negedge clk);
    check("sat_timer_100", state_timer, 100);
    repeat (65435) @(negedge clk);
    check("sat_timer_max", state_timer, 65535);
    @(negedge clk);
    check("sat_timer_hold", state_timer, 65535);
    check("sat_still_disch", fsm_state, DISCH);
    wait_enter(OFF, 10000, "sat_off");
    is_machine = 1'b0;
    wait_enter(IDLE, 10, "sat_idle");
    check("sat_normal_cnt", normal_cnt, exp_normal % 256);

    // Asynchronous reset in the middle of a discharge.
    push(CHARGE, 4, 0, 0); push(GAP, 1, 0, 0);
    Ton_data = 16'd3; Toff_data = 16'd5; inductor_charging_time = 16'd4;
    is_machine = 1'b1;
    wait_enter(DISCH, 50, "arst_disch");
    repeat (4) @(negedge clk);
    check("arst_pre_charge_en", charge_en, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_charge_en", charge_en, 0);
    check("arst_gap_en", gap_en, 0);
    check("arst_state", fsm_state, IDLE);
    check("arst_timer", state_timer, 0);
    check("arst_normal", normal_cnt, 0);
    check("arst_null", null_cnt, 0);
    check("arst_pulse_start", pulse_start, 0);
    @(negedge clk);
    is_machine = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
